// File: rtl/dm_pkg.sv
// Shared data-memory encodings: DMType access sizes, responder FSM states,
// and the load-extension helper used on the response path.
package dm_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } dm_state_e;

   // Picks the addressed lane of a little-endian word and sign/zero-extends it.
   function automatic logic [31:0] dm_extend(input logic [2:0]  dmtype,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
      logic [15:0] half;
      logic [7:0]  byte_v;
      half   = word[{off[1], 4'b0000} +: 16];
      byte_v = word[{off, 3'b000} +: 8];
      case (dmtype)
         DM_HALF:   return {{16{half[15]}}, half};
         DM_HALF_U: return {16'h0000, half};
         DM_BYTE:   return {{24{byte_v[7]}}, byte_v};
         DM_BYTE_U: return {24'h000000, byte_v};
         default:   return word;
      endcase
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents are deliberately not reset.
module dm_ram #(
   parameter int unsigned DEPTH_WORDS = 128,
   parameter int unsigned AW          = 7
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_unit.sv
// Data-memory responder: latches one request, checks it, performs the lane-enabled
// store or load against dm_ram, and holds the extended result until accepted.
module dm_unit
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 128
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_dmtype,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   dm_state_e     state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    dmtype_q, dmtype_d;
   logic [1:0]    off_q, off_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;

   logic          req_err;
   logic          ram_we, ram_re;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata, ram_rdata;

   always_comb begin
      req_err = 1'b0;
      case (req_dmtype)
         DM_WORD:             req_err = (req_addr[1:0] != 2'b00);
         DM_HALF, DM_HALF_U:  req_err = req_addr[0];
         DM_BYTE, DM_BYTE_U:  req_err = 1'b0;
         default:             req_err = 1'b1;
      endcase
      if ({2'b00, req_addr[31:2]} >= DEPTH_WORDS) req_err = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      dmtype_d  = dmtype_q;
      off_d     = off_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               dmtype_d = req_dmtype;
               off_d    = req_addr[1:0];
               idx_d    = req_addr[AW+1:2];
               wdata_d  = req_wdata;
               err_d    = req_err;
               state_d  = req_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            ram_we  = we_q;
            ram_re  = ~we_q;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         dmtype_q <= '0;
         off_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         dmtype_q <= dmtype_d;
         off_q    <= off_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   // Narrow stores replicate the source lane so the byte enables alone pick the target.
   always_comb begin
      case (dmtype_q)
         DM_HALF, DM_HALF_U: begin
            lane_be    = off_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_q[15:0]}};
         end
         DM_BYTE, DM_BYTE_U: begin
            lane_be    = 4'b0001 << off_q;
            lane_wdata = {4{wdata_q[7:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = wdata_q;
         end
      endcase
   end

   dm_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_ram (
      .clk    (clk),
      .we_i   (ram_we),
      .be_i   (lane_be),
      .re_i   (ram_re),
      .addr_i (idx_q),
      .wdata_i(lane_wdata),
      .rdata_o(ram_rdata)
   );

   assign rsp_rdata = (state_q == RESP && !we_q && !err_q)
                      ? dm_extend(dmtype_q, off_q, ram_rdata) : '0;
   assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dm_unit.sv
// Bench for dm_unit: directed vector table, stall/reset corner sequences, then
// randomized traffic checked against a byte-addressed reference memory.
module tb_dm_unit;

   localparam int unsigned DEPTH = 128;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_dmtype;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   dm_unit #(.DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_dmtype(req_dmtype),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   typedef struct {
      logic        we;
      logic [2:0]  dt;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] mem_m [4*DEPTH];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic void add(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input logic err);
      tbl.push_back('{we, dt, addr, wd, rd, err});
   endfunction

   // Reference: byte-addressed memory, size/sign from the access type.
   function automatic void model(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int unsigned size;
      logic        sgn;
      logic [31:0] v;
      rd = 32'h0;
      case (dt)
         3'd0:    begin size = 4; sgn = 1'b0; end
         3'd1:    begin size = 2; sgn = 1'b1; end
         3'd2:    begin size = 2; sgn = 1'b0; end
         3'd3:    begin size = 1; sgn = 1'b1; end
         3'd4:    begin size = 1; sgn = 1'b0; end
         default: begin size = 0; sgn = 1'b0; end
      endcase
      er = (size == 0) || (addr % size != 0) || (addr >= 4*DEPTH);
      if (er) return;
      if (we) begin
         for (int i = 0; i < int'(size); i++) mem_m[addr + i] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < int'(size); i++) v = v | (32'(mem_m[addr + i]) << (8*i));
         if (sgn && v >= (32'd1 << (8*size - 1))) v = v | ~((32'd1 << (8*size)) - 32'd1);
         rd = v;
      end
   endfunction

   task automatic do_req(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                         input logic [31:0] wd, input int unsigned stall, input logic pulse,
                         output logic [31:0] rd, output logic er, output int unsigned lat);
      int unsigned n;
      rd = 32'h0; er = 1'b0; lat = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_dmtype = dt; req_addr = addr; req_wdata = wd;
      rsp_ready = (stall == 0);
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_dmtype = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 10);
      lat = n;
      if (!rsp_valid) begin
         chk("rsp_timeout", rsp_valid, 1);
         rsp_ready = 1'b1;
         return;
      end
      rd = rsp_rdata;
      er = rsp_err;
      chk("req_ready_busy", req_ready, 0);
      for (int i = 0; i < int'(stall); i++) begin
         if (pulse && i == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_dmtype = 3'b000;
            req_addr = addr; req_wdata = 32'hBADBAD00;
         end
         if (pulse && i == 3) req_valid = 1'b0;
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1);
         chk("stall_rdata", rsp_rdata, rd);
         chk("stall_err", rsp_err, er);
         chk("stall_req_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_valid", rsp_valid, 0);
      chk("post_hs_ready", req_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0]  rd, mrd;
      logic         er, mer;
      int unsigned  lat;
      logic         we;
      logic [2:0]   dt;
      logic [31:0]  addr, wd;

      rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
      #1;
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
      #20;
      @(negedge clk) rstn = 1'b1;

      add(1, 3'd0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
      add(0, 3'd0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
      add(1, 3'd3, 32'h11,  32'h0000007F, 32'h0,        0);
      add(0, 3'd3, 32'h11,  32'h0,        32'h0000007F, 0);
      add(0, 3'd3, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
      add(0, 3'd4, 32'h13,  32'h0,        32'h000000DE, 0);
      add(0, 3'd0, 32'h10,  32'h0,        32'hDEAD7FEF, 0);
      add(0, 3'd3, 32'h10,  32'h0,        32'hFFFFFFEF, 0);
      add(0, 3'd2, 32'h10,  32'h0,        32'h00007FEF, 0);
      add(0, 3'd1, 32'h12,  32'h0,        32'hFFFFDEAD, 0);
      add(1, 3'd0, 32'h20,  32'h12345678, 32'h0,        0);
      add(1, 3'd1, 32'h22,  32'hCAFE8001, 32'h0,        0);
      add(0, 3'd1, 32'h22,  32'h0,        32'hFFFF8001, 0);
      add(0, 3'd2, 32'h22,  32'h0,        32'h00008001, 0);
      add(0, 3'd0, 32'h20,  32'h0,        32'h80015678, 0);
      add(1, 3'd4, 32'h21,  32'h000000AB, 32'h0,        0);
      add(0, 3'd0, 32'h20,  32'h0,        32'h8001AB78, 0);
      add(0, 3'd0, 32'h12,  32'h0,        32'h0,        1);
      add(1, 3'd1, 32'h23,  32'hFFFFFFFF, 32'h0,        1);
      add(0, 3'd0, 32'h20,  32'h0,        32'h8001AB78, 0);
      add(1, 3'd5, 32'h10,  32'h00000000, 32'h0,        1);
      add(0, 3'd7, 32'h10,  32'h0,        32'h0,        1);
      add(0, 3'd0, 32'h10,  32'h0,        32'hDEAD7FEF, 0);
      add(1, 3'd0, 32'h200, 32'h55555555, 32'h0,        1);
      add(0, 3'd3, 32'h200, 32'h0,        32'h0,        1);
      add(1, 3'd0, 32'h30,  32'h11111111, 32'h0,        0);

      for (int i = 0; i < tbl.size(); i++) begin
         do_req(tbl[i].we, tbl[i].dt, tbl[i].addr, tbl[i].wd, 0, 1'b0, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
         chk($sformatf("vec%0d_err", i), er, tbl[i].err);
         chk($sformatf("vec%0d_latency", i), lat, tbl[i].err ? 1 : 2);
      end

      // Reset asserted while a store sits in ACCESS must drop the store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_dmtype = 3'd0; req_addr = 32'h30;
      req_wdata = 32'hAAAAAAAA; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("access_req_ready", req_ready, 0);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_req_ready", req_ready, 1);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_rsp_rdata", rsp_rdata, 0);
      chk("rst_mid_rsp_err", rsp_err, 0);
      @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      do_req(0, 3'd0, 32'h30, 32'h0, 0, 1'b0, rd, er, lat);
      chk("abort_store_rdata", rd, 32'h11111111);

      // Five-cycle response stall with a stray request pulse inside it.
      do_req(0, 3'd0, 32'h30, 32'h0, 5, 1'b1, rd, er, lat);
      chk("stall_load_rdata", rd, 32'h11111111);
      chk("stall_load_latency", lat, 2);
      do_req(0, 3'd0, 32'h30, 32'h0, 0, 1'b0, rd, er, lat);
      chk("pulse_ignored_rdata", rd, 32'h11111111);

      for (int unsigned w = 0; w < DEPTH; w++) begin
         wd = $urandom;
         model(1'b1, 3'd0, 32'(w*4), wd, mrd, mer);
         do_req(1'b1, 3'd0, 32'(w*4), wd, 0, 1'b0, rd, er, lat);
      end

      for (int n = 0; n < 400; n++) begin
         we = 1'($urandom_range(0, 1));
         dt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0)
            addr = 32'(4*DEPTH + $urandom_range(0, 4095));
         else
            addr = 32'($urandom_range(0, DEPTH-1) * 4 + $urandom_range(0, 3));
         wd = $urandom;
         model(we, dt, addr, wd, mrd, mer);
         do_req(we, dt, addr, wd, $urandom_range(0, 2), 1'b0, rd, er, lat);
         chk($sformatf("rnd%0d_rdata", n), rd, mrd);
         chk($sformatf("rnd%0d_err", n), er, mer);
         chk($sformatf("rnd%0d_latency", n), lat, mer ? 1 : 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
